mnacidpro_sequencer: RTL and testbench
======================================

# mnacidpro_sequencer

Protocol sequencer for the three-lane nucleic-acid purification chip (mnacidpro). It drives every pneumatic control line of the chip through a fixed load → lyse → wash → elute → collect protocol, with programmable per-phase durations. It enforces break-before-make gaps between phases and generates the three-phase peristaltic pump pattern. It sits between the host/test controller and the chip's valve control inputs; all outputs feed solenoid drivers directly.

## Interface
- DUR_W, 16 — width of the phase-duration inputs (clock cycles).
- PUMP_DIV, 8 — clocks per peristaltic pump step (≥1).
- GAP_CYC, 4 — all-closed break-before-make cycles between phases (≥1).
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request a protocol run; accepted only in IDLE.
- abort  in  1  terminate the run; safe shutdown.
- load_dur, lyse_dur, wash_dur, elute_dur, collect_dur  in  DUR_W each  phase lengths; sampled on the accepted start.
- busy  out  1  high from the cycle after start is accepted until IDLE is re-entered.
- done  out  1  one-cycle pulse on normal completion.
- aborted  out  1  one-cycle pulse when an abort finishes.
- phase  out  3  current state encoding, for debug.
- lysis_ctl, wash_ctl, elute_ctl, horiz_ctl, vertical_ctl, loop_exit_ctl, bead_vtl_ctl, bead_trap_ctl, collection_ctl, waste_ctl  out  1 each  valve control lines; 1 = pressurised = valve closed.
- pump1, pump2, pump3  out  1 each  pump valve lines; same polarity.

## Operation
- States: IDLE(0), LOAD(1), LYSE(2), WASH(3), ELUTE(4), COLLECT(5), GAP(6), DONE(7).
- Reset: state IDLE; all valve and pump outputs 1; busy, done and aborted 0; counters 0.
- Open valves per state (every other line stays 1):
  - IDLE, GAP, DONE: none.
  - LOAD: horiz, bead_vtl.
  - LYSE: lysis, vertical, pump.
  - WASH: wash, vertical, loop_exit, waste, pump.
  - ELUTE: elute, vertical, pump.
  - COLLECT: loop_exit, bead_trap, collection, pump.
- Sequence: IDLE → LOAD → GAP → LYSE → GAP → WASH → GAP → ELUTE → GAP → COLLECT → GAP → DONE → IDLE.
  - A registered "next phase" pointer records where GAP exits to.
- Each active phase lasts exactly its sampled duration in clocks.
  - A duration of 0 skips that phase; no extra GAP is inserted for it.
  - If all durations are 0, the run goes straight to GAP → DONE.
- GAP lasts GAP_CYC clocks with all lines closed.
- Pump: while the state enables the pump, pump1..3 cycle through six steps, (p1,p2,p3) = 110, 100, 101, 001, 011, 010.
  - Each step holds PUMP_DIV clocks; the sequence wraps 5 → 0.
  - The step resets to 0 on every pump-enabled phase entry.
  - Pump lines are 111 whenever the pump is disabled.
- Abort, in any non-IDLE state other than DONE: go to GAP with next = IDLE, then pulse aborted on the IDLE entry cycle.
  - Abort during GAP restarts the GAP count.
  - Abort in IDLE or DONE is ignored.
  - Abort wins over a simultaneous start.
- Start outside IDLE is ignored.

## Timing
- All outputs are registered; valve lines change on the clock edge where the state changes.
- After start is sampled high in IDLE: LOAD outputs appear at edge +1, and busy goes high at the same edge.
- Phase length = dur clocks, counted from the first cycle in the state.
- Total latency from start to done, with n active phases: sum(dur) + n·GAP_CYC + 1 clocks.
  - With no active phases: GAP_CYC + 1.
- done is high during the DONE cycle. busy falls on the IDLE entry.
- Counters are DUR_W bits, load dur−1, and exit at 0; no wrap.
- Reset mid-run forces the reset values asynchronously.

## Structure
- Package mnacidpro_pkg holds:
  - the state enum;
  - the per-state valve-mask constants (10-bit open masks);
  - the pump-step pattern array;
  - localparam PUMP_STEPS = 6.
- Sub-module peristaltic_pump_drv (inputs clk, rst_n, en; output p[2:0]) holds the divider and the step counter.

## Test plan
- Reset, then idle 20 clocks → all 13 lines 1; busy, done and aborted 0.
- Durations 5/6/7/8/9, GAP_CYC 4 → each state lasts its exact count; five GAPs of 4 clocks each; done exactly 56 clocks after start; masks match per state.
- LYSE of 60 clocks, PUMP_DIV 8 → pump steps 110, 100, 101, 001, 011, 010, then wrap to 110, each held 8 clocks; pump lines 111 in the following GAP.
- wash_dur = 0, others 3 → WASH never appears; ELUTE follows the LYSE GAP directly; done at 4·3 + 4·4 + 1 = 29 clocks.
- Abort asserted in the 2nd cycle of ELUTE → all lines 1 at the next edge; 4 GAP clocks; aborted pulses once; done never asserts.
- start held high during a run, and start + abort asserted together in IDLE → no restart; the state stays IDLE in the second case; then rst_n pulsed low mid-WASH → immediate all-closed IDLE.

Source files
------------

// File: rtl/mnacidpro_pkg.sv
// rtl/mnacidpro_pkg.sv - shared states, valve masks and pump pattern for the mnacidpro sequencer
//
// Purpose: common definitions imported by the sequencer and the pump driver.
// Contents: state enum, 10-bit per-state open masks, pump step pattern.
// Valve mask bit order (bit 9 .. bit 0):
//   lysis, wash, elute, horiz, vertical, loop_exit, bead_vtl, bead_trap, collection, waste
package mnacidpro_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_LYSE    = 3'd2,
        ST_WASH    = 3'd3,
        ST_ELUTE   = 3'd4,
        ST_COLLECT = 3'd5,
        ST_GAP     = 3'd6,
        ST_DONE    = 3'd7
    } state_e;

    localparam int PUMP_STEPS = 6;

    localparam logic [9:0] V_LYSIS      = 10'b10_0000_0000;
    localparam logic [9:0] V_WASH       = 10'b01_0000_0000;
    localparam logic [9:0] V_ELUTE      = 10'b00_1000_0000;
    localparam logic [9:0] V_HORIZ      = 10'b00_0100_0000;
    localparam logic [9:0] V_VERTICAL   = 10'b00_0010_0000;
    localparam logic [9:0] V_LOOP_EXIT  = 10'b00_0001_0000;
    localparam logic [9:0] V_BEAD_VTL   = 10'b00_0000_1000;
    localparam logic [9:0] V_BEAD_TRAP  = 10'b00_0000_0100;
    localparam logic [9:0] V_COLLECTION = 10'b00_0000_0010;
    localparam logic [9:0] V_WASTE      = 10'b00_0000_0001;

    localparam logic [9:0] MASK_NONE    = 10'b00_0000_0000;
    localparam logic [9:0] MASK_LOAD    = V_HORIZ | V_BEAD_VTL;
    localparam logic [9:0] MASK_LYSE    = V_LYSIS | V_VERTICAL;
    localparam logic [9:0] MASK_WASH    = V_WASH | V_VERTICAL | V_LOOP_EXIT | V_WASTE;
    localparam logic [9:0] MASK_ELUTE   = V_ELUTE | V_VERTICAL;
    localparam logic [9:0] MASK_COLLECT = V_LOOP_EXIT | V_BEAD_TRAP | V_COLLECTION;

    // Entry [0] is the first step {p1,p2,p3} = 110; the sequence wraps 5 -> 0.
    localparam logic [PUMP_STEPS-1:0][2:0] PUMP_PATTERN = {
        3'b010, 3'b011, 3'b001, 3'b101, 3'b100, 3'b110
    };

    function automatic logic [9:0] open_mask(input state_e s);
        logic [9:0] m;
        m = MASK_NONE;
        case (s)
            ST_LOAD:    m = MASK_LOAD;
            ST_LYSE:    m = MASK_LYSE;
            ST_WASH:    m = MASK_WASH;
            ST_ELUTE:   m = MASK_ELUTE;
            ST_COLLECT: m = MASK_COLLECT;
            default:    m = MASK_NONE;
        endcase
        return m;
    endfunction

    function automatic logic pump_enabled(input state_e s);
        return (s == ST_LYSE) || (s == ST_WASH) || (s == ST_ELUTE) || (s == ST_COLLECT);
    endfunction

endpackage

// File: rtl/peristaltic_pump_drv.sv
// rtl/peristaltic_pump_drv.sv - three-phase peristaltic pump pattern generator
//
// Purpose: steps the pump valves through the six-step pattern while enabled.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   en     pump enable for the coming cycle (driven from the sequencer's next state)
//   p      {pump1, pump2, pump3}, registered; 111 while disabled
module peristaltic_pump_drv
    import mnacidpro_pkg::*;
#(
    parameter int PUMP_DIV = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    output logic [2:0] p
);

    localparam int                DIV_W     = (PUMP_DIV > 1) ? $clog2(PUMP_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(PUMP_DIV - 1);
    localparam logic [2:0]        STEP_LAST = 3'(PUMP_STEPS - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       step_q, step_d;
    logic [2:0]       p_q, p_d;

    // Counters sit at zero while disabled, so the first enabled cycle always
    // shows step 0: every pump phase is preceded by a disabled cycle.
    always_comb begin
        div_d  = '0;
        step_d = '0;
        p_d    = 3'b111;
        if (en) begin
            p_d = PUMP_PATTERN[step_q];
            if (div_q == DIV_LAST) begin
                div_d  = '0;
                step_d = (step_q == STEP_LAST) ? 3'd0 : step_q + 3'd1;
            end else begin
                div_d  = div_q + DIV_W'(1);
                step_d = step_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q  <= '0;
            step_q <= '0;
            p_q    <= 3'b111;
        end else begin
            div_q  <= div_d;
            step_q <= step_d;
            p_q    <= p_d;
        end
    end

    assign p = p_q;

endmodule

// File: rtl/mnacidpro_sequencer.sv
// rtl/mnacidpro_sequencer.sv - load/lyse/wash/elute/collect protocol sequencer
//
// Purpose: runs the purification protocol with programmable phase lengths,
// all-closed gaps between phases, abort to safe shutdown, pump pattern.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start, abort               run request (IDLE only) / safe termination
//   load_dur .. collect_dur    phase lengths in clocks, sampled on accepted start
//   busy, done, aborted        run status (done/aborted are one-cycle pulses)
//   phase                      current state encoding
//   *_ctl, pump1..3            valve lines, 1 = pressurised = closed
module mnacidpro_sequencer
    import mnacidpro_pkg::*;
#(
    parameter int DUR_W    = 16,
    parameter int PUMP_DIV = 8,
    parameter int GAP_CYC  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [DUR_W-1:0] load_dur,
    input  logic [DUR_W-1:0] lyse_dur,
    input  logic [DUR_W-1:0] wash_dur,
    input  logic [DUR_W-1:0] elute_dur,
    input  logic [DUR_W-1:0] collect_dur,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [2:0]       phase,
    output logic             lysis_ctl,
    output logic             wash_ctl,
    output logic             elute_ctl,
    output logic             horiz_ctl,
    output logic             vertical_ctl,
    output logic             loop_exit_ctl,
    output logic             bead_vtl_ctl,
    output logic             bead_trap_ctl,
    output logic             collection_ctl,
    output logic             waste_ctl,
    output logic             pump1,
    output logic             pump2,
    output logic             pump3
);

    localparam logic [DUR_W-1:0] GAP_LOAD = DUR_W'(GAP_CYC - 1);
    localparam logic [DUR_W-1:0] ONE      = DUR_W'(1);

    // Index 0 = load ... 4 = collect, i.e. state encoding minus one.
    typedef logic [4:0][DUR_W-1:0] durs_t;

    state_e     state_q, state_d;
    state_e     next_q, next_d;     // where GAP exits to
    logic [DUR_W-1:0] cnt_q, cnt_d;
    durs_t      dur_q, dur_d;
    durs_t      in_durs;
    logic       busy_q, done_q, aborted_q;
    logic [9:0] closed_q;
    logic [2:0] pump_p;

    assign in_durs = {collect_dur, elute_dur, wash_dur, lyse_dur, load_dur};

    function automatic logic [4:0] nonzero(input durs_t d);
        return {|d[4], |d[3], |d[2], |d[1], |d[0]};
    endfunction

    // First phase after 'after' (state encoding) with a nonzero length, else DONE.
    function automatic state_e first_active(input logic [2:0] after, input logic [4:0] nz);
        state_e r;
        r = ST_DONE;
        if      (after < 3'd1 && nz[0]) r = ST_LOAD;
        else if (after < 3'd2 && nz[1]) r = ST_LYSE;
        else if (after < 3'd3 && nz[2]) r = ST_WASH;
        else if (after < 3'd4 && nz[3]) r = ST_ELUTE;
        else if (after < 3'd5 && nz[4]) r = ST_COLLECT;
        return r;
    endfunction

    function automatic logic [DUR_W-1:0] dur_of(input state_e s, input durs_t d);
        logic [DUR_W-1:0] r;
        r = '0;
        case (s)
            ST_LOAD:    r = d[0];
            ST_LYSE:    r = d[1];
            ST_WASH:    r = d[2];
            ST_ELUTE:   r = d[3];
            ST_COLLECT: r = d[4];
            default:    r = '0;
        endcase
        return r;
    endfunction

    function automatic logic is_phase(input state_e s);
        return (s == ST_LOAD) || (s == ST_LYSE) || (s == ST_WASH) ||
               (s == ST_ELUTE) || (s == ST_COLLECT);
    endfunction

    always_comb begin
        state_e first;
        state_d = state_q;
        next_d  = next_q;
        cnt_d   = cnt_q;
        dur_d   = dur_q;
        first   = ST_DONE;
        case (state_q)
            ST_IDLE: begin
                // abort wins over a simultaneous start
                if (start && !abort) begin
                    dur_d = in_durs;
                    first = first_active(3'd0, nonzero(in_durs));
                    if (first == ST_DONE) begin
                        state_d = ST_GAP;
                        next_d  = ST_DONE;
                        cnt_d   = GAP_LOAD;
                    end else begin
                        state_d = first;
                        cnt_d   = dur_of(first, in_durs) - ONE;
                    end
                end
            end
            ST_LOAD, ST_LYSE, ST_WASH, ST_ELUTE, ST_COLLECT: begin
                if (abort) begin
                    state_d = ST_GAP;
                    next_d  = ST_IDLE;
                    cnt_d   = GAP_LOAD;
                end else if (cnt_q == '0) begin
                    state_d = ST_GAP;
                    next_d  = first_active(state_q, nonzero(dur_q));
                    cnt_d   = GAP_LOAD;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            ST_GAP: begin
                if (abort) begin
                    state_d = ST_GAP;
                    next_d  = ST_IDLE;
                    cnt_d   = GAP_LOAD;
                end else if (cnt_q == '0) begin
                    state_d = next_q;
                    cnt_d   = is_phase(next_q) ? dur_of(next_q, dur_q) - ONE : '0;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so every line changes on
    // the same edge as the state itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            next_q    <= ST_IDLE;
            cnt_q     <= '0;
            dur_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            closed_q  <= '1;
        end else begin
            state_q   <= state_d;
            next_q    <= next_d;
            cnt_q     <= cnt_d;
            dur_q     <= dur_d;
            busy_q    <= (state_d != ST_IDLE);
            done_q    <= (state_d == ST_DONE);
            aborted_q <= (state_q == ST_GAP) && (state_d == ST_IDLE);
            closed_q  <= ~open_mask(state_d);
        end
    end

    peristaltic_pump_drv #(
        .PUMP_DIV (PUMP_DIV)
    ) u_pump (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (pump_enabled(state_d)),
        .p     (pump_p)
    );

    assign busy           = busy_q;
    assign done           = done_q;
    assign aborted        = aborted_q;
    assign phase          = state_q;
    assign lysis_ctl      = closed_q[9];
    assign wash_ctl       = closed_q[8];
    assign elute_ctl      = closed_q[7];
    assign horiz_ctl      = closed_q[6];
    assign vertical_ctl   = closed_q[5];
    assign loop_exit_ctl  = closed_q[4];
    assign bead_vtl_ctl   = closed_q[3];
    assign bead_trap_ctl  = closed_q[2];
    assign collection_ctl = closed_q[1];
    assign waste_ctl      = closed_q[0];
    assign pump1          = pump_p[2];
    assign pump2          = pump_p[1];
    assign pump3          = pump_p[0];

endmodule

// File: tb/tb_mnacidpro_sequencer.sv
// tb/tb_mnacidpro_sequencer.sv - self-checking bench for mnacidpro_sequencer
module tb_mnacidpro_sequencer;

    localparam int DUR_W    = 16;
    localparam int PUMP_DIV = 8;
    localparam int GAP_CYC  = 4;

    localparam int S_IDLE = 0, S_LOAD = 1, S_LYSE = 2, S_WASH = 3;
    localparam int S_ELUTE = 4, S_COLLECT = 5, S_GAP = 6, S_DONE = 7;

    logic clk = 1'b0;
    logic rst_n, start, abort;
    logic [DUR_W-1:0] load_dur, lyse_dur, wash_dur, elute_dur, collect_dur;
    logic busy, done, aborted;
    logic [2:0] phase;
    logic lysis_ctl, wash_ctl, elute_ctl, horiz_ctl, vertical_ctl, loop_exit_ctl;
    logic bead_vtl_ctl, bead_trap_ctl, collection_ctl, waste_ctl;
    logic pump1, pump2, pump3;

    always #5 clk = ~clk;

    mnacidpro_sequencer #(
        .DUR_W (DUR_W), .PUMP_DIV (PUMP_DIV), .GAP_CYC (GAP_CYC)
    ) dut (
        .clk (clk), .rst_n (rst_n), .start (start), .abort (abort),
        .load_dur (load_dur), .lyse_dur (lyse_dur), .wash_dur (wash_dur),
        .elute_dur (elute_dur), .collect_dur (collect_dur),
        .busy (busy), .done (done), .aborted (aborted), .phase (phase),
        .lysis_ctl (lysis_ctl), .wash_ctl (wash_ctl), .elute_ctl (elute_ctl),
        .horiz_ctl (horiz_ctl), .vertical_ctl (vertical_ctl),
        .loop_exit_ctl (loop_exit_ctl), .bead_vtl_ctl (bead_vtl_ctl),
        .bead_trap_ctl (bead_trap_ctl), .collection_ctl (collection_ctl),
        .waste_ctl (waste_ctl), .pump1 (pump1), .pump2 (pump2), .pump3 (pump3)
    );

    logic [9:0] valves;
    logic [2:0] pumps;
    assign valves = {lysis_ctl, wash_ctl, elute_ctl, horiz_ctl, vertical_ctl,
                     loop_exit_ctl, bead_vtl_ctl, bead_trap_ctl, collection_ctl, waste_ctl};
    assign pumps  = {pump1, pump2, pump3};

    // Model: the expected timeline of the run as a queue of per-cycle entries.
    typedef struct {
        int st;
        int k;      // cycle index within the current state occurrence
        bit abrt;   // aborted pulse expected in this cycle
    } entry_t;

    entry_t exp_q[$];
    entry_t cur;

    int n_checks = 0;
    int n_fail   = 0;
    bit measuring = 0;
    int lat_cnt = 0;
    int lat_seen = -1;
    int done_pulses = 0;
    int abort_pulses = 0;
    bit seen_wash = 0;
    bit cap_en = 0;
    logic [2:0] pump_cap [64];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic logic [9:0] exp_valves(input int st);
        logic [9:0] opn;
        opn = '0;
        case (st)
            S_LOAD:    begin opn[6] = 1; opn[3] = 1; end
            S_LYSE:    begin opn[9] = 1; opn[5] = 1; end
            S_WASH:    begin opn[8] = 1; opn[5] = 1; opn[4] = 1; opn[0] = 1; end
            S_ELUTE:   begin opn[7] = 1; opn[5] = 1; end
            S_COLLECT: begin opn[4] = 1; opn[2] = 1; opn[1] = 1; end
            default:   opn = '0;
        endcase
        return ~opn;
    endfunction

    function automatic logic [2:0] exp_pump(input int st, input int k);
        logic [2:0] pat [6];
        pat = '{3'b110, 3'b100, 3'b101, 3'b001, 3'b011, 3'b010};
        if (st >= S_LYSE && st <= S_COLLECT) return pat[(k / PUMP_DIV) % 6];
        return 3'b111;
    endfunction

    function automatic entry_t mk(input int st, input int k, input bit a);
        entry_t e;
        e.st = st; e.k = k; e.abrt = a;
        return e;
    endfunction

    task automatic push_gap();
        for (int g = 0; g < GAP_CYC; g++) exp_q.push_back(mk(S_GAP, g, 1'b0));
    endtask

    task automatic build_run();
        int d [5];
        int n;
        d[0] = int'(load_dur); d[1] = int'(lyse_dur); d[2] = int'(wash_dur);
        d[3] = int'(elute_dur); d[4] = int'(collect_dur);
        n = 0;
        for (int i = 0; i < 5; i++) begin
            if (d[i] != 0) begin
                for (int k = 0; k < d[i]; k++) exp_q.push_back(mk(i + 1, k, 1'b0));
                push_gap();
                n++;
            end
        end
        if (n == 0) push_gap();
        exp_q.push_back(mk(S_DONE, 0, 1'b0));
    endtask

    task automatic check_cycle();
        chk("phase",   32'(phase),   32'(cur.st));
        chk("valves",  32'(valves),  32'(exp_valves(cur.st)));
        chk("pumps",   32'(pumps),   32'(exp_pump(cur.st, cur.k)));
        chk("busy",    32'(busy),    32'(cur.st != S_IDLE));
        chk("done",    32'(done),    32'(cur.st == S_DONE));
        chk("aborted", 32'(aborted), 32'(cur.abrt));
        if (done) done_pulses++;
        if (aborted) abort_pulses++;
        if (phase == 3'(S_WASH)) seen_wash = 1;
        if (measuring && done) begin
            lat_seen = lat_cnt;
            measuring = 0;
        end
        if (cap_en && cur.st == S_LYSE && cur.k < 64) pump_cap[cur.k] = pumps;
    endtask

    // Called at a negedge: drive inputs for the next edge, advance the model,
    // then check the outputs half a cycle after that edge.
    task automatic tick(input logic s, input logic a);
        start = s;
        abort = a;
        if (cur.st == S_IDLE && s && !a) begin
            build_run();
        end else if (a && cur.st != S_IDLE && cur.st != S_DONE) begin
            exp_q.delete();
            push_gap();
            exp_q.push_back(mk(S_IDLE, 0, 1'b1));
        end
        if (exp_q.size() > 0) cur = exp_q.pop_front();
        else cur = mk(S_IDLE, 0, 1'b0);
        @(posedge clk);
        if (measuring) lat_cnt++;
        @(negedge clk);
        check_cycle();
    endtask

    task automatic set_durs(input int a, input int b, input int c, input int d, input int e);
        load_dur = DUR_W'(a); lyse_dur = DUR_W'(b); wash_dur = DUR_W'(c);
        elute_dur = DUR_W'(d); collect_dur = DUR_W'(e);
    endtask

    task automatic start_run();
        measuring = 1; lat_cnt = 0; lat_seen = -1;
        tick(1'b1, 1'b0);
    endtask

    task automatic run_until_idle(input bit hold_start, input int ab_st, input int ab_k,
                                  input int budget);
        int n;
        n = 0;
        while (!(cur.st == S_IDLE && exp_q.size() == 0) && n < budget) begin
            tick(hold_start && cur.st != S_DONE, (cur.st == ab_st) && (cur.k == ab_k));
            n++;
        end
        chk("run_within_budget", 32'(n < budget), 32'd1);
    endtask

    task automatic check_reset_lines(input string tag);
        chk({tag, "_lines"},   32'({valves, pumps}), 32'h1fff);
        chk({tag, "_status"},  32'({busy, done, aborted}), 32'd0);
        chk({tag, "_phase"},   32'(phase), 32'd0);
    endtask

    initial begin
        int n;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        set_durs(0, 0, 0, 0, 0);
        cur = mk(S_IDLE, 0, 1'b0);
        repeat (2) @(negedge clk);
        check_reset_lines("reset");
        rst_n = 1'b1;

        // idle after reset
        repeat (20) tick(1'b0, 1'b0);
        check_reset_lines("idle20");

        // 5/6/7/8/9: 35 + 5*4 + 1 = 56
        set_durs(5, 6, 7, 8, 9);
        start_run();
        run_until_idle(1'b0, -1, -1, 200);
        chk("latency_5to9", 32'(lat_seen), 32'd56);
        chk("done_once_5to9", 32'(done_pulses), 32'd1);

        // long LYSE for the pump wrap
        cap_en = 1;
        set_durs(2, 60, 1, 1, 1);
        start_run();
        run_until_idle(1'b0, -1, -1, 200);
        cap_en = 0;
        chk("pump_k0",  32'(pump_cap[0]),  32'b110);
        chk("pump_k7",  32'(pump_cap[7]),  32'b110);
        chk("pump_k8",  32'(pump_cap[8]),  32'b100);
        chk("pump_k16", 32'(pump_cap[16]), 32'b101);
        chk("pump_k47", 32'(pump_cap[47]), 32'b010);
        chk("pump_k48", 32'(pump_cap[48]), 32'b110);
        chk("pump_k59", 32'(pump_cap[59]), 32'b100);

        // skipped WASH: 12 + 16 + 1 = 29
        seen_wash = 0;
        set_durs(3, 3, 0, 3, 3);
        start_run();
        run_until_idle(1'b0, -1, -1, 200);
        chk("latency_skip", 32'(lat_seen), 32'd29);
        chk("wash_absent", 32'(seen_wash), 32'd0);

        // all zero: GAP + 1
        set_durs(0, 0, 0, 0, 0);
        start_run();
        run_until_idle(1'b0, -1, -1, 50);
        chk("latency_zero", 32'(lat_seen), 32'(GAP_CYC + 1));

        // abort in the 2nd ELUTE cycle
        done_pulses = 0; abort_pulses = 0;
        set_durs(2, 2, 2, 3, 2);
        tick(1'b1, 1'b0);
        run_until_idle(1'b0, S_ELUTE, 1, 200);
        chk("abort_pulse_once", 32'(abort_pulses), 32'd1);
        chk("abort_no_done", 32'(done_pulses), 32'd0);

        // start held through a run, then start+abort in IDLE
        done_pulses = 0;
        set_durs(2, 3, 2, 2, 2);
        tick(1'b1, 1'b0);
        run_until_idle(1'b1, -1, -1, 200);
        chk("held_start_done_once", 32'(done_pulses), 32'd1);
        tick(1'b1, 1'b1);
        tick(1'b0, 1'b0);
        chk("start_abort_idle", 32'(phase), 32'(S_IDLE));

        // asynchronous reset mid-WASH
        set_durs(2, 2, 6, 2, 2);
        tick(1'b1, 1'b0);
        n = 0;
        while (!(cur.st == S_WASH && cur.k == 2) && n < 100) begin
            tick(1'b0, 1'b0);
            n++;
        end
        chk("reached_wash", 32'(phase), 32'(S_WASH));
        #2 rst_n = 1'b0;
        #1;
        check_reset_lines("async_reset");
        exp_q.delete();
        cur = mk(S_IDLE, 0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) tick(1'b0, 1'b0);

        // randomized traffic; durations change every cycle to prove sampling
        for (int i = 0; i < 3000; i++) begin
            load_dur    = ($urandom_range(0, 3) == 0) ? '0 : DUR_W'($urandom_range(1, 9));
            lyse_dur    = ($urandom_range(0, 3) == 0) ? '0 : DUR_W'($urandom_range(1, 9));
            wash_dur    = ($urandom_range(0, 3) == 0) ? '0 : DUR_W'($urandom_range(1, 9));
            elute_dur   = ($urandom_range(0, 3) == 0) ? '0 : DUR_W'($urandom_range(1, 9));
            collect_dur = ($urandom_range(0, 3) == 0) ? '0 : DUR_W'($urandom_range(1, 9));
            tick(($urandom_range(0, 7) == 0), ($urandom_range(0, 59) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
